wbc_pwr_seq: RTL and testbench



---
 rtl/wbc_pkg.sv | 37 +++
 rtl/wbc_pwr_seq_if.sv | 30 +++
 rtl/wbc_sync2.sv | 26 ++
 rtl/wbc_pwr_seq.sv | 177 +++++++++++++++++
 tb/tb_wbc_pwr_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wbc_pkg.sv
// Shared definitions for the wbc_* blocks: power-sequencer state codes and a ceil-log2 helper.
package wbc_pkg;

  localparam logic [2:0] PwrOff    = 3'd0;
  localparam logic [2:0] PwrInit   = 3'd1;
  localparam logic [2:0] PwrWaitAc = 3'd2;
  localparam logic [2:0] PwrStart  = 3'd3;
  localparam logic [2:0] PwrRun    = 3'd4;
  localparam logic [2:0] PwrPfail  = 3'd5;
  localparam logic [2:0] PwrDown   = 3'd6;
  localparam logic [2:0] PwrHalt   = 3'd7;

  typedef enum logic [2:0] {
    StOff    = PwrOff,
    StInit   = PwrInit,
    StWaitAc = PwrWaitAc,
    StStart  = PwrStart,
    StRun    = PwrRun,
    StPfail  = PwrPfail,
    StDown   = PwrDown,
    StHalt   = PwrHalt
  } pwr_state_e;

  // Bits needed to hold value-1; never less than 1 so counters stay legal.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      width++;
    end
    if (width == 0) begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/wbc_pwr_seq_if.sv
// CPU-core handshake bundle of the power sequencer; master is the sequencer, slave is the core.
interface wbc_pwr_seq_if;
  logic cpu_start_req;
  logic cpu_start_ack;
  logic cpu_pfail_req;
  logic cpu_pfail_ack;
  logic cpu_reset_cmd;
  logic cpu_halt;
  logic init_busy;

  modport master (
    output cpu_start_req,
    output cpu_pfail_req,
    output cpu_halt,
    output init_busy,
    input  cpu_start_ack,
    input  cpu_pfail_ack,
    input  cpu_reset_cmd
  );

  modport slave (
    input  cpu_start_req,
    input  cpu_pfail_req,
    input  cpu_halt,
    input  init_busy,
    output cpu_start_ack,
    output cpu_pfail_ack,
    output cpu_reset_cmd
  );
endinterface

// File: rtl/wbc_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module wbc_sync2 #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/wbc_pwr_seq.sv
// CPU-side power sequencer: synchronizes DCLO/ACLO, sequences start/power-fail handshakes
// with the core and generates bus INIT on power-up and on the RESET instruction.
module wbc_pwr_seq
  import wbc_pkg::*;
#(
  parameter int unsigned INIT_WIDTH = 16,
  parameter int unsigned PF_TIMEOUT = 1024
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          sys_dclo,
  input  logic          sys_aclo,
  wbc_pwr_seq_if.master cpu,
  output logic          bus_init,
  output logic [2:0]    pwr_state
);

  localparam int unsigned CntMax = (INIT_WIDTH > PF_TIMEOUT) ? INIT_WIDTH : PF_TIMEOUT;
  localparam int unsigned CntW   = log2(CntMax);
  localparam int unsigned RstW   = log2(INIT_WIDTH);

  localparam logic [CntW-1:0] InitLoad = CntW'(INIT_WIDTH - 1);
  localparam logic [CntW-1:0] PfLoad   = CntW'(PF_TIMEOUT - 1);
  localparam logic [RstW-1:0] RstLoad  = RstW'(INIT_WIDTH - 1);

  logic dclo_s;
  logic aclo_s;

  pwr_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic            busy_q, busy_d;
  logic            halt_q, halt_d;
  logic            bus_init_q, bus_init_d;
  logic            start_req_q, start_req_d;
  logic            pfail_req_q, pfail_req_d;

  wbc_sync2 #(
    .ResetVal (1'b1)
  ) u_sync_dclo (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (sys_dclo),
    .q_o   (dclo_s)
  );

  wbc_sync2 #(
    .ResetVal (1'b1)
  ) u_sync_aclo (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (sys_aclo),
    .q_o   (aclo_s)
  );

  // Main sequencing FSM; the shared counter times INIT and the DOWN window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dclo_s) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StOff: begin
          state_d = StInit;
          cnt_d   = InitLoad;
        end
        StInit: begin
          if (cnt_q == '0) begin
            state_d = StWaitAc;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StWaitAc: begin
          if (!aclo_s) begin
            state_d = StStart;
          end
        end
        StStart: begin
          // An ack in the same cycle as ACLO wins; RUN then sees ACLO next cycle.
          if (cpu.cpu_start_ack) begin
            state_d = StRun;
          end else if (aclo_s) begin
            state_d = StWaitAc;
          end
        end
        StRun: begin
          if (aclo_s) begin
            state_d = StPfail;
          end
        end
        StPfail: begin
          if (cpu.cpu_pfail_ack) begin
            state_d = StDown;
            cnt_d   = PfLoad;
          end
        end
        StDown: begin
          if (!aclo_s) begin
            state_d = StStart;
          end else if (cnt_q == '0) begin
            state_d = StHalt;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StHalt: begin
          if (!aclo_s) begin
            state_d = StStart;
          end
        end
        default: begin
          state_d = StOff;
        end
      endcase
    end
  end

  // RESET-instruction INIT pulse; may keep running into PFAIL/DOWN.
  always_comb begin
    busy_d    = busy_q;
    rst_cnt_d = rst_cnt_q;
    if (state_d == StOff) begin
      busy_d    = 1'b0;
      rst_cnt_d = '0;
    end else if (cpu.cpu_reset_cmd && (state_q == StRun)) begin
      busy_d    = 1'b1;
      rst_cnt_d = RstLoad;
    end else if (busy_q) begin
      if (rst_cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        rst_cnt_d = rst_cnt_q - RstW'(1);
      end
    end
  end

  always_comb begin
    halt_d      = (state_d == StOff) || (state_d == StInit) ||
                  (state_d == StWaitAc) || (state_d == StHalt);
    bus_init_d  = (state_d == StOff) || (state_d == StInit) || busy_d;
    start_req_d = (state_d == StStart);
    pfail_req_d = (state_d == StPfail);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      busy_q      <= 1'b0;
      halt_q      <= 1'b1;
      bus_init_q  <= 1'b1;
      start_req_q <= 1'b0;
      pfail_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      busy_q      <= busy_d;
      halt_q      <= halt_d;
      bus_init_q  <= bus_init_d;
      start_req_q <= start_req_d;
      pfail_req_q <= pfail_req_d;
    end
  end

  assign cpu.cpu_start_req = start_req_q;
  assign cpu.cpu_pfail_req = pfail_req_q;
  assign cpu.cpu_halt      = halt_q;
  assign cpu.init_busy     = busy_q;
  assign bus_init          = bus_init_q;
  assign pwr_state         = state_q;

endmodule

// File: tb/tb_wbc_pwr_seq.sv
// Scoreboard bench for wbc_pwr_seq: stimulus queues cycle-tagged expected outputs, a negedge
// monitor pops and compares them.
module tb_wbc_pwr_seq;

  localparam logic [2:0] SOff    = 3'd0;
  localparam logic [2:0] SInit   = 3'd1;
  localparam logic [2:0] SWaitAc = 3'd2;
  localparam logic [2:0] SStart  = 3'd3;
  localparam logic [2:0] SRun    = 3'd4;
  localparam logic [2:0] SPfail  = 3'd5;
  localparam logic [2:0] SDown   = 3'd6;
  localparam logic [2:0] SHalt   = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       halt;
    logic       init;
    logic       sreq;
    logic       preq;
    logic       busy;
  } snap_t;

  typedef struct {
    int unsigned at;
    string       name;
    snap_t       exp;
  } item_t;

  item_t       sb[$];
  int unsigned cyc = 0;
  int          passed = 0;
  int          total = 0;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       sys_dclo = 1'b1;
  logic       sys_aclo = 1'b1;
  logic       bus_init;
  logic [2:0] pwr_state;

  wbc_pwr_seq_if cpu_if ();

  wbc_pwr_seq #(
    .INIT_WIDTH (4),
    .PF_TIMEOUT (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .sys_dclo  (sys_dclo),
    .sys_aclo  (sys_aclo),
    .cpu       (cpu_if),
    .bus_init  (bus_init),
    .pwr_state (pwr_state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    snap_t act;
    act = {pwr_state, cpu_if.cpu_halt, bus_init, cpu_if.cpu_start_req, cpu_if.cpu_pfail_req,
           cpu_if.init_busy};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        total++;
        if (sb[i].at == cyc && act == sb[i].exp) begin
          passed++;
        end else begin
          $display("FAIL %s @cyc %0d (due %0d): got st=%0d halt=%b init=%b sreq=%b preq=%b busy=%b, want st=%0d halt=%b init=%b sreq=%b preq=%b busy=%b",
                   sb[i].name, cyc, sb[i].at, act.st, act.halt, act.init, act.sreq, act.preq,
                   act.busy, sb[i].exp.st, sb[i].exp.halt, sb[i].exp.init, sb[i].exp.sreq,
                   sb[i].exp.preq, sb[i].exp.busy);
        end
        sb.delete(i);
      end
    end
  end

  // Expected outputs per state, straight from the state/output table.
  function automatic snap_t mk(input logic [2:0] st, input logic busy);
    snap_t s;
    s.st   = st;
    s.halt = (st == SOff) || (st == SInit) || (st == SWaitAc) || (st == SHalt);
    s.init = (st == SOff) || (st == SInit) || busy;
    s.sreq = (st == SStart);
    s.preq = (st == SPfail);
    s.busy = busy;
    return s;
  endfunction

  task automatic chk(input int unsigned d, input string nm, input logic [2:0] st,
                     input logic busy);
    item_t it;
    it.at   = cyc + d;
    it.name = nm;
    it.exp  = mk(st, busy);
    sb.push_back(it);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    cpu_if.cpu_start_ack = 1'b0;
    cpu_if.cpu_pfail_ack = 1'b0;
    cpu_if.cpu_reset_cmd = 1'b0;

    // Reset and cold start
    step(3);                                   // cyc 3
    sys_rst = 1'b0;
    chk(0, "reset_state", SOff, 1'b0);
    chk(1, "off_after_reset", SOff, 1'b0);
    step(1);                                   // cyc 4
    sys_dclo = 1'b0;
    chk(2, "dclo_in_sync", SOff, 1'b0);
    chk(3, "init_entry", SInit, 1'b0);
    chk(6, "init_last", SInit, 1'b0);
    chk(7, "wait_ac", SWaitAc, 1'b0);
    step(20);                                  // cyc 24
    sys_aclo = 1'b0;
    chk(2, "aclo_in_sync", SWaitAc, 1'b0);
    chk(3, "start_req", SStart, 1'b0);
    step(4);                                   // cyc 28
    chk(0, "start_held", SStart, 1'b0);
    chk(1, "run", SRun, 1'b0);
    cpu_if.cpu_start_ack = 1'b1;
    step(1);
    cpu_if.cpu_start_ack = 1'b0;               // cyc 29

    // Power fail with warm recovery just before timeout
    step(2);                                   // cyc 31
    sys_aclo = 1'b1;
    chk(2, "run_before_pf", SRun, 1'b0);
    chk(3, "pfail_req", SPfail, 1'b0);
    step(5);                                   // cyc 36
    cpu_if.cpu_pfail_ack = 1'b1;
    chk(1, "down", SDown, 1'b0);
    step(1);
    cpu_if.cpu_pfail_ack = 1'b0;               // cyc 37, DOWN cycle 1
    step(4);                                   // cyc 41, DOWN cycle 5
    sys_aclo = 1'b0;
    chk(2, "down_hold", SDown, 1'b0);
    chk(3, "warm_restart", SStart, 1'b0);
    step(5);                                   // cyc 46
    cpu_if.cpu_start_ack = 1'b1;
    chk(1, "run_again", SRun, 1'b0);
    step(1);
    cpu_if.cpu_start_ack = 1'b0;               // cyc 47

    // Power fail timeout, then DC loss
    step(1);                                   // cyc 48
    sys_aclo = 1'b1;
    chk(3, "pfail_req_2", SPfail, 1'b0);
    step(4);                                   // cyc 52
    cpu_if.cpu_pfail_ack = 1'b1;
    chk(1, "down_2", SDown, 1'b0);
    step(1);
    cpu_if.cpu_pfail_ack = 1'b0;               // cyc 53
    chk(7, "down_last", SDown, 1'b0);
    chk(8, "halt_timeout", SHalt, 1'b0);
    step(9);                                   // cyc 62
    sys_dclo = 1'b1;
    chk(2, "halt_hold", SHalt, 1'b0);
    chk(3, "dclo_off", SOff, 1'b0);
    step(3);                                   // cyc 65
    sys_dclo = 1'b0;
    sys_aclo = 1'b0;
    chk(3, "reinit", SInit, 1'b0);
    chk(7, "rewait", SWaitAc, 1'b0);
    chk(8, "restart", SStart, 1'b0);
    step(8);                                   // cyc 73
    cpu_if.cpu_start_ack = 1'b1;
    chk(1, "run_3", SRun, 1'b0);
    step(1);
    cpu_if.cpu_start_ack = 1'b0;               // cyc 74

    // RESET instruction: single pulse, then a retriggered one
    step(1);                                   // cyc 75
    cpu_if.cpu_reset_cmd = 1'b1;
    chk(1, "rst_busy_first", SRun, 1'b1);
    chk(4, "rst_busy_last", SRun, 1'b1);
    chk(5, "rst_done", SRun, 1'b0);
    step(1);
    cpu_if.cpu_reset_cmd = 1'b0;               // cyc 76
    step(6);                                   // cyc 82
    cpu_if.cpu_reset_cmd = 1'b1;
    chk(1, "retrig_first", SRun, 1'b1);
    chk(6, "retrig_last", SRun, 1'b1);
    chk(7, "retrig_done", SRun, 1'b0);
    step(1);
    cpu_if.cpu_reset_cmd = 1'b0;               // cyc 83
    step(1);                                   // cyc 84, busy cycle 2
    cpu_if.cpu_reset_cmd = 1'b1;
    step(1);
    cpu_if.cpu_reset_cmd = 1'b0;               // cyc 85

    // DCLO rise coincident with pfail ack: OFF wins
    step(5);                                   // cyc 90
    sys_aclo = 1'b1;
    chk(3, "pfail_req_3", SPfail, 1'b0);
    step(3);                                   // cyc 93
    sys_dclo = 1'b1;
    chk(2, "pfail_pending", SPfail, 1'b0);
    chk(3, "dclo_beats_ack", SOff, 1'b0);
    step(2);                                   // cyc 95
    cpu_if.cpu_pfail_ack = 1'b1;
    step(1);
    cpu_if.cpu_pfail_ack = 1'b0;               // cyc 96

    // ACLO rise coincident with start ack: RUN, then PFAIL
    step(1);                                   // cyc 97
    sys_dclo = 1'b0;
    sys_aclo = 1'b0;
    chk(8, "start_4", SStart, 1'b0);
    step(9);                                   // cyc 106
    sys_aclo = 1'b1;
    chk(2, "start_pre_ack", SStart, 1'b0);
    chk(3, "ack_beats_aclo", SRun, 1'b0);
    chk(4, "pfail_follows", SPfail, 1'b0);
    step(2);                                   // cyc 108
    cpu_if.cpu_start_ack = 1'b1;
    step(1);
    cpu_if.cpu_start_ack = 1'b0;               // cyc 109

    // Synchronous reset while in DOWN
    step(2);                                   // cyc 111
    cpu_if.cpu_pfail_ack = 1'b1;
    chk(1, "down_3", SDown, 1'b0);
    step(1);
    cpu_if.cpu_pfail_ack = 1'b0;               // cyc 112
    step(2);                                   // cyc 114
    sys_rst = 1'b1;
    chk(0, "down_pre_rst", SDown, 1'b0);
    chk(1, "mid_reset", SOff, 1'b0);
    step(1);                                   // cyc 115
    sys_rst = 1'b0;
    chk(1, "post_reset", SOff, 1'b0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      step(1);
    end
    if (sb.size() > 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
